exu_alu_issue: RTL and testbench

Execute-stage front end of the NPC core that sits on the requester side of the combinational ALU. It accepts decoded RV32I integer instructions over a valid/ready handshake, derives the ALU control and operand signals, launches them from a registered operand stage, captures the ALU result into a result stage, and presents it to writeback over a second valid/ready handshake. Two-stage pipeline with full backpressure and one instruction per cycle throughput.

---
 rtl/exu_alu_issue.sv | 145 ++++++++++++++
 tb/tb_exu_alu_issue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_issue.sv
// Execute-stage issue front end: decodes RV32I ALU ops, drives the external ALU
// from the S1 register stage, and captures the result in S2. Optional EXU_ISSUE_STAT_EN.
module exu_alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   output logic [2:0]      alu_sel,
   output logic            alu_a_l,
   output logic            alu_l_r,
   output logic            alu_s_u,
   output logic            alu_add_sub,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_data,
   output logic            out_wen
`ifdef EXU_ISSUE_STAT_EN
  ,output logic [31:0]     stat_retired
`endif
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic            s1_valid, s1_wen;
   logic [4:0]      s1_rd;
   logic            s2_free, s1_go, accept;
   logic [2:0]      d_sel;
   logic            d_a_l, d_l_r, d_s_u, d_add_sub, d_wen;
   logic [XLEN-1:0] d_a, d_b;

   assign s2_free  = !out_valid || out_ready;
   assign s1_go    = s1_valid && s2_free;
   assign in_ready = !s1_valid || s2_free;
   assign accept   = in_valid && in_ready;

   always_comb begin
      d_sel     = 3'b000;
      d_a_l     = 1'b0;
      d_l_r     = 1'b0;
      d_s_u     = 1'b0;
      d_add_sub = 1'b0;
      d_wen     = 1'b0;
      d_a       = '0;
      d_b       = '0;
      case (in_opcode)
         OPC_OP, OPC_IMM: begin
            d_a   = in_rs1;
            d_b   = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
            d_wen = 1'b1;
            d_sel = in_funct3;
            // select mirrors funct3 except SLTU, which shares the compare path
            case (in_funct3)
               3'b000: d_add_sub = (in_opcode == OPC_OP) && in_funct7_5;
               3'b001: begin d_l_r = 1'b0; d_a_l = 1'b1; end
               3'b010: d_add_sub = 1'b1;
               3'b011: begin d_sel = 3'b010; d_add_sub = 1'b1; d_s_u = 1'b1; end
               3'b101: begin d_l_r = 1'b1; d_a_l = !in_funct7_5; end
               default: ;
            endcase
         end
         OPC_LUI: begin
            d_sel = 3'b011;
            d_b   = in_imm;
            d_wen = 1'b1;
         end
         OPC_AUIPC: begin
            d_a   = in_pc;
            d_b   = in_imm;
            d_wen = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_wen      <= 1'b0;
         s1_rd       <= '0;
         alu_sel     <= '0;
         alu_a_l     <= 1'b0;
         alu_l_r     <= 1'b0;
         alu_s_u     <= 1'b0;
         alu_add_sub <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
      end else if (accept) begin
         s1_valid    <= 1'b1;
         s1_wen      <= d_wen;
         s1_rd       <= in_rd;
         alu_sel     <= d_sel;
         alu_a_l     <= d_a_l;
         alu_l_r     <= d_l_r;
         alu_s_u     <= d_s_u;
         alu_add_sub <= d_add_sub;
         alu_a       <= d_a;
         alu_b       <= d_b;
      end else if (s1_go) begin
         s1_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_rd    <= '0;
         out_wen   <= 1'b0;
         out_data  <= '0;
      end else if (s1_go) begin
         out_valid <= 1'b1;
         out_rd    <= s1_rd;
         out_wen   <= s1_wen;
         out_data  <= s1_wen ? alu_result : '0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef EXU_ISSUE_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stat_retired <= '0;
      else if (out_valid && out_ready)
         stat_retired <= stat_retired + 32'd1;
   end
`endif

endmodule

// File: tb/tb_exu_alu_issue.sv
// Scoreboard bench for exu_alu_issue: ISA-level reference model, external ALU model,
// directed corner cases, backpressure, mid-stream reset, randomized stream.
module tb_exu_alu_issue;
   localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011, LUI = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111, BR = 7'b1100011;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, in_funct7_5 = 1'b0;
   logic [6:0] in_opcode = '0;
   logic [2:0] in_funct3 = '0;
   logic [4:0] in_rd = '0;
   logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
   logic [2:0] alu_sel;
   logic alu_a_l, alu_l_r, alu_s_u, alu_add_sub;
   logic [31:0] alu_a, alu_b, alu_result;
   logic out_valid, out_ready = 1'b1, out_wen;
   logic [4:0] out_rd;
   logic [31:0] out_data;
`ifdef EXU_ISSUE_STAT_EN
   logic [31:0] stat_retired;
`endif

   typedef struct {logic [4:0] rd; logic [31:0] data; logic wen;} exp_t;
   exp_t sb[$];
   int n_vec = 0, n_err = 0, n_acc = 0, n_ret = 0, mode = 0;

   exu_alu_issue #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rd(in_rd), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_sel(alu_sel), .alu_a_l(alu_a_l), .alu_l_r(alu_l_r), .alu_s_u(alu_s_u),
      .alu_add_sub(alu_add_sub), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_data(out_data), .out_wen(out_wen)
`ifdef EXU_ISSUE_STAT_EN
     ,.stat_retired(stat_retired)
`endif
   );

   always #5 clk = ~clk;

   // external combinational ALU
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         3'b000: alu_result = alu_add_sub ? alu_a - alu_b : alu_a + alu_b;
         3'b001, 3'b101: begin
            if (!alu_l_r)     alu_result = alu_a << alu_b[4:0];
            else if (alu_a_l) alu_result = alu_a >> alu_b[4:0];
            else              alu_result = $signed(alu_a) >>> alu_b[4:0];
         end
         3'b010: alu_result = {31'd0, alu_s_u ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b))};
         3'b011: alu_result = alu_b;
         3'b100: alu_result = alu_a ^ alu_b;
         3'b110: alu_result = alu_a | alu_b;
         default: alu_result = alu_a & alu_b;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RV32I architectural result of the instruction
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [4:0] rd, input logic [31:0] pc, rs1, rs2, imm);
      exp_t e;
      logic [31:0] b;
      e.rd = rd; e.wen = 1'b1; e.data = '0;
      b = (op == OP) ? rs2 : imm;
      if (op == OP || op == IMM) begin
         case (f3)
            3'd0: e.data = (op == OP && f7) ? rs1 - b : rs1 + b;
            3'd1: e.data = rs1 << b[4:0];
            3'd2: e.data = {31'd0, $signed(rs1) < $signed(b)};
            3'd3: e.data = {31'd0, rs1 < b};
            3'd4: e.data = rs1 ^ b;
            3'd5: begin
               if (f7) e.data = $signed(rs1) >>> b[4:0];
               else    e.data = rs1 >> b[4:0];
            end
            3'd6: e.data = rs1 | b;
            default: e.data = rs1 & b;
         endcase
      end else if (op == LUI)   e.data = imm;
      else if (op == AUIPC)     e.data = pc + imm;
      else                      e.wen = 1'b0;
      return e;
   endfunction

   // call right after a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [31:0] pc, rs1, rs2, imm);
      int t;
      in_opcode = op; in_funct3 = f3; in_funct7_5 = f7; in_rd = rd;
      in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
      t = 0;
      forever begin
         #1;
         if (in_ready) break;
         if (++t > 200) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected acceptance");
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      sb.push_back(model(op, f3, f7, rd, pc, rs1, rs2, imm));
      n_acc++;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic directed(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [4:0] rd, input logic [31:0] rs1, rs2, imm,
                           input logic [2:0] sel, input logic a_l, l_r, s_u, add_sub,
                           input logic [31:0] data, input logic wen);
      issue(op, f3, f7, rd, 32'h1000, rs1, rs2, imm);
      #1;
      check({nm, "_sel"}, {29'd0, alu_sel}, {29'd0, sel});
      check({nm, "_ctl"}, {28'd0, alu_a_l, alu_l_r, alu_s_u, alu_add_sub},
            {28'd0, a_l, l_r, s_u, add_sub});
      check({nm, "_s1_outvalid"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk); #1;
      check({nm, "_outvalid"}, {31'd0, out_valid}, 32'd1);
      check({nm, "_data"}, out_data, data);
      check({nm, "_wen"}, {31'd0, out_wen}, {31'd0, wen});
      if (wen) check({nm, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
      @(negedge clk);
   endtask

   // scoreboard monitor, also owns out_ready
   always begin
      exp_t e;
      @(negedge clk);
      case (mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 9) < 7);
         default: out_ready = 1'b0;
      endcase
      #1;
      if (rst_n && out_valid && out_ready) begin
         n_ret++;
         if (sb.size() == 0) begin
            check("unexpected_response", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_wen", {31'd0, out_wen}, {31'd0, e.wen});
            check("sb_data", out_data, e.data);
            if (e.wen) check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check("drain_pending", sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_alu_ab", alu_a | alu_b, 32'd0);
      check("rst_out_rd_wen", {26'd0, out_rd, out_wen}, 32'd0);
      @(negedge clk);

      directed("sub", OP, 3'b000, 1'b1, 5'd3, 32'd5, 32'd7, 32'd0, 3'b000, 0, 0, 0, 1, 32'hFFFFFFFE, 1);
      directed("srai", IMM, 3'b101, 1'b1, 5'd4, 32'h80000000, 32'd0, 32'd4, 3'b101, 0, 1, 0, 0, 32'hF8000000, 1);
      directed("sltu", OP, 3'b011, 1'b0, 5'd5, 32'd1, 32'hFFFFFFFF, 32'd0, 3'b010, 0, 0, 1, 1, 32'd1, 1);
      directed("branch", BR, 3'b000, 1'b0, 5'd6, 32'd9, 32'd9, 32'h40, 3'b000, 0, 0, 0, 0, 32'd0, 0);
      directed("lui", LUI, 3'b000, 1'b0, 5'd7, 32'd0, 32'd0, 32'h12345000, 3'b011, 0, 0, 0, 0, 32'h12345000, 1);

      // backpressure: 4 ADDIs while writeback stalls for 3 cycles
      mode = 2; base = n_acc;
      fork
         for (int i = 0; i < 4; i++) issue(IMM, 3'b000, 1'b0, 5'(10 + i), 32'd0, 32'(100 + i), 32'd0, 32'(i));
         begin
            repeat (3) @(negedge clk);
            #2;
            check("bp_accepts", n_acc - base, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_s1_hold", alu_a, 32'd101);
            mode = 0;
         end
      join
      drain();

      // mid-stream reset with both stages full
      @(negedge clk);
      mode = 2;
      issue(LUI, 3'b000, 1'b0, 5'd1, 32'd0, 32'd0, 32'd0, 32'hABCDE000);
      issue(IMM, 3'b000, 1'b0, 5'd2, 32'd0, 32'd1, 32'd0, 32'd1);
      #1;
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef EXU_ISSUE_STAT_EN
      check("arst_stat", stat_retired, 32'd0);
`endif
      sb.delete(); n_ret = 0;
      @(negedge clk); #3 rst_n = 1'b1;
      #1;
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      mode = 1;
      @(negedge clk);

      // randomized stream with random backpressure
      for (int n = 0; n < 200; n++) begin
         logic [6:0] op;
         int r;
         r = $urandom_range(0, 9);
         if (r < 4)      op = OP;
         else if (r < 7) op = IMM;
         else if (r == 7) op = LUI;
         else if (r == 8) op = AUIPC;
         else begin
            case ($urandom_range(0, 3))
               0: op = BR;
               1: op = 7'b0000011;
               2: op = 7'b0100011;
               default: op = 7'b1101111;
            endcase
         end
         issue(op, 3'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      mode = 0;
      drain();
      repeat (2) @(negedge clk);
`ifdef EXU_ISSUE_STAT_EN
      check("stat_retired", stat_retired, 32'(n_ret));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
